main_memory_responder: RTL

//  Main-memory responder on the far side of the memory arbiter. Accepts a

---
 rtl/main_memory_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Fixed-latency word-access memory responder behind the memory arbiter.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (flags/blocks accesses above the RAM).
module main_memory_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       mem_addr,
   input  logic              mem_re,
   input  logic              mem_wr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic [DATA_W-1:0] data_out,
   output logic              mem_ready,
   output logic              mem_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int LANES = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic                capture, access;

   logic [ADDR_W-1:0]   addr_reg;
   logic                wr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [3:0]          wstrb_reg;
   logic                oob_reg;
   logic                oob_in;

   logic                ready_reg, err_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [DATA_W-1:0]   ram [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob_in = |mem_addr[31:ADDR_W+2];
   logic unused_in;
   assign unused_in = ^{mem_re, mem_addr[1:0]};
`else
   assign oob_in = 1'b0;
   logic unused_in;
   assign unused_in = ^{mem_re, mem_addr[1:0], mem_addr[31:ADDR_W+2]};
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      access     = 1'b0;
      case (state_reg)
         IDLE: begin
            capture    = 1'b1;
            cnt_next   = 4'(LATENCY - 1);
            state_next = WAIT;
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               access     = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ready_reg <= access;
         err_reg   <= access & oob_reg;
      end
   end

   // Request is frozen here; the requester's inputs are ignored until the next IDLE.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         addr_reg  <= mem_addr[ADDR_W+1:2];
         wr_reg    <= mem_wr;
         wdata_reg <= mem_wdata;
         wstrb_reg <= mem_wstrb;
         oob_reg   <= oob_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && access) begin
         if (wr_reg && !oob_reg) begin
            for (int i = 0; i < LANES; i++) begin
               if (wstrb_reg[i]) ram[addr_reg][i*8 +: 8] <= wdata_reg[i*8 +: 8];
            end
         end
         rdata_reg <= ram[addr_reg];
      end
   end

   // Outputs come only from registers; writes and out-of-range reads return zero.
   assign data_out  = (ready_reg && !wr_reg && !oob_reg) ? rdata_reg : '0;
   assign mem_ready = ready_reg;
   assign mem_err   = err_reg;

endmodule
